ptw_mlvl: RTL and testbench

- Parametrised multi-level page table walker. Successor to the fixed two-level ptw.
- Sits between the TLB miss path and the memory port. Accepts a virtual address and a root table base, then walks LEVELS levels of page table.
- Returns the leaf PTE, the level it was found at, and a fault flag.
- Supports superpages (leaf above the last level) and detects malformed PTEs.

---
 rtl/ptw_mlvl.sv | 239 +++++++++++++++++++++++
 tb/tb_ptw_mlvl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mlvl.sv
// Parametrised multi-level page table walker between the TLB miss path and memory.
// Optional single-entry last-level table cache enabled by defining PTW_PDE_CACHE_EN.
module ptw_mlvl #(
  parameter int XLEN      = 32,
  parameter int LEVELS    = 2,
  parameter int VPN_BITS  = 10,
  parameter int PAGE_BITS = 12,
  parameter int PTE_BYTES = 4,
  parameter int LVL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ptw_req_valid_i,
  output logic             ptw_req_ready_o,
  input  logic [XLEN-1:0]  ptw_vaddr_i,
  input  logic [XLEN-1:0]  ptw_root_i,
  input  logic             ptw_flush_i,
  output logic             ptw_resp_valid_o,
  input  logic             ptw_resp_ready_i,
  output logic [XLEN-1:0]  ptw_pte_o,
  output logic [LVL_W-1:0] ptw_level_o,
  output logic             ptw_fault_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [XLEN-1:0]  mem_addr_o,
  input  logic             mem_resp_valid_i,
  output logic             mem_resp_ready_o,
  input  logic [XLEN-1:0]  mem_data_i
);

  localparam int PTE_SHIFT = $clog2(PTE_BYTES);
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] VPN_MASK = (ONE << VPN_BITS) - ONE;
  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(LEVELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MREQ,
    S_MWAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   vaddr_q, vaddr_d;
  logic [XLEN-1:0]   base_q, base_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [XLEN-1:0]   pte_q, pte_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fault_q, fault_d;

  logic              pte_v, pte_r, pte_w, pte_x;
  logic              pte_bad, pte_leaf, pte_misaligned;
  logic [XLEN-1:0]   next_base;

  // VPN field of the given level, selected with constant shifts only.
  function automatic logic [XLEN-1:0] vpn_of(input logic [XLEN-1:0] va,
                                             input logic [LVL_W-1:0] l);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (l == LVL_W'(i)) r = (va >> (PAGE_BITS + i * VPN_BITS)) & VPN_MASK;
    end
    return r;
  endfunction

  // PPN bits that must be zero for a leaf found at level l to be a legal superpage.
  function automatic logic [XLEN-1:0] super_mask(input logic [LVL_W-1:0] l);
    logic [XLEN-1:0] m;
    m = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (l == LVL_W'(i)) m = (ONE << (i * VPN_BITS)) - ONE;
    end
    return m;
  endfunction

  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] va);
    return va >> (PAGE_BITS + VPN_BITS);
  endfunction

  assign pte_v          = mem_data_i[0];
  assign pte_r          = mem_data_i[1];
  assign pte_w          = mem_data_i[2];
  assign pte_x          = mem_data_i[3];
  assign pte_bad        = !pte_v || (pte_w && !pte_r);
  assign pte_leaf       = pte_r || pte_x;
  assign pte_misaligned = ((mem_data_i >> PAGE_BITS) & super_mask(lvl_q)) != '0;
  assign next_base      = {mem_data_i[XLEN-1:PAGE_BITS], {PAGE_BITS{1'b0}}};

`ifdef PTW_PDE_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]   cache_tag_q, cache_tag_d;
  logic [XLEN-1:0]   cache_root_q, cache_root_d;
  logic [XLEN-1:0]   cache_base_q, cache_base_d;
  logic [XLEN-1:0]   root_q, root_d;
  logic              cache_hit;

  assign cache_hit = cache_valid_q && (tag_of(ptw_vaddr_i) == cache_tag_q) &&
                     (ptw_root_i == cache_root_q);
`endif

  always_comb begin
    state_d          = state_q;
    vaddr_d          = vaddr_q;
    base_d           = base_q;
    lvl_d            = lvl_q;
    pte_d            = pte_q;
    level_d          = level_q;
    fault_d          = fault_q;
    ptw_req_ready_o  = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    ptw_resp_valid_o = 1'b0;
`ifdef PTW_PDE_CACHE_EN
    cache_valid_d    = cache_valid_q;
    cache_tag_d      = cache_tag_q;
    cache_root_d     = cache_root_q;
    cache_base_d     = cache_base_q;
    root_d           = root_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        ptw_req_ready_o = 1'b1;
`ifdef PTW_PDE_CACHE_EN
        // A flush coinciding with a request wins, so that request cannot hit.
        if (ptw_flush_i) cache_valid_d = 1'b0;
`endif
        if (ptw_req_valid_i) begin
          vaddr_d = ptw_vaddr_i;
          base_d  = ptw_root_i;
          lvl_d   = TOP_LVL;
          state_d = S_MREQ;
`ifdef PTW_PDE_CACHE_EN
          root_d  = ptw_root_i;
          if (cache_hit && !ptw_flush_i) begin
            base_d = cache_base_q;
            lvl_d  = '0;
          end
`endif
        end
      end

      S_MREQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = S_MWAIT;
      end

      S_MWAIT: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          if (pte_bad) begin
            fault_d = 1'b1;
            pte_d   = '0;
            level_d = lvl_q;
            state_d = S_RESP;
          end else if (pte_leaf) begin
            fault_d = pte_misaligned;
            pte_d   = mem_data_i;
            level_d = lvl_q;
            state_d = S_RESP;
          end else if (lvl_q == '0) begin
            fault_d = 1'b1;
            pte_d   = mem_data_i;
            level_d = lvl_q;
            state_d = S_RESP;
          end else begin
            base_d  = next_base;
            lvl_d   = lvl_q - LVL_W'(1);
            state_d = S_MREQ;
`ifdef PTW_PDE_CACHE_EN
            if (lvl_q == LVL_W'(1)) begin
              cache_valid_d = 1'b1;
              cache_tag_d   = tag_of(vaddr_q);
              cache_root_d  = root_q;
              cache_base_d  = next_base;
            end
`endif
          end
        end
      end

      S_RESP: begin
        ptw_resp_valid_o = 1'b1;
        if (ptw_resp_ready_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vaddr_q <= '0;
      base_q  <= '0;
      lvl_q   <= '0;
      pte_q   <= '0;
      level_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      base_q  <= base_d;
      lvl_q   <= lvl_d;
      pte_q   <= pte_d;
      level_q <= level_d;
      fault_q <= fault_d;
    end
  end

`ifdef PTW_PDE_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_root_q  <= '0;
      cache_base_q  <= '0;
      root_q        <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_root_q  <= cache_root_d;
      cache_base_q  <= cache_base_d;
      root_q        <= root_d;
    end
  end
`endif

  // Address is only driven while a request is outstanding so it reads 0 otherwise.
  assign mem_addr_o  = (state_q == S_MREQ) ?
                       base_q + (vpn_of(vaddr_q, lvl_q) << PTE_SHIFT) : '0;
  assign ptw_pte_o   = pte_q;
  assign ptw_level_o = level_q;
  assign ptw_fault_o = fault_q;

  logic unused_bits;
  assign unused_bits = ^{ptw_flush_i, vaddr_q};

endmodule

// File: tb/tb_ptw_mlvl.sv
// Directed self-checking bench for ptw_mlvl with a zero-wait PTE memory model.
// Cache expectations follow whether PTW_PDE_CACHE_EN is defined for the build.
module tb_ptw_mlvl;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] vaddrIn;
  logic [31:0] rootIn;
  logic        flush;
  logic        respValid;
  logic        respReady;
  logic [31:0] pte;
  logic [0:0]  level;
  logic        fault;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memAddr;
  logic        memRespValid;
  logic        memRespReady;
  logic [31:0] memData;

  int          checkCount;
  int          passCount;
  logic [31:0] readLog[$];
  logic [31:0] gotPte;
  logic [31:0] gotLevel;
  logic [31:0] gotFault;
  int          walkLatency;
  logic        stableOk;

  ptw_mlvl dut (
    .clk             (clk),
    .rst             (rst),
    .ptw_req_valid_i (reqValid),
    .ptw_req_ready_o (reqReady),
    .ptw_vaddr_i     (vaddrIn),
    .ptw_root_i      (rootIn),
    .ptw_flush_i     (flush),
    .ptw_resp_valid_o(respValid),
    .ptw_resp_ready_i(respReady),
    .ptw_pte_o       (pte),
    .ptw_level_o     (level),
    .ptw_fault_o     (fault),
    .mem_req_valid_o (memReqValid),
    .mem_req_ready_i (memReqReady),
    .mem_addr_o      (memAddr),
    .mem_resp_valid_i(memRespValid),
    .mem_resp_ready_o(memRespReady),
    .mem_data_i      (memData)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Page table image used by every walk; unlisted addresses read as zero.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h1000: return 32'h00002001;
      32'h1004: return 32'h00003001;
      32'h1008: return 32'h1240000F;
      32'h100C: return 32'h00000000;
      32'h1010: return 32'h0000100F;
      32'h1014: return 32'h00000005;
      32'h2000: return 32'h1000000F;
      32'h2004: return 32'h1100000F;
      32'h200C: return 32'h00005001;
      32'h3004: return 32'h2100000F;
      default:  return 32'h00000000;
    endcase
  endfunction

  // Memory answers the cycle after a request is accepted and logs every read.
  always @(posedge clk) begin
    if (rst) begin
      memRespValid <= 1'b0;
      memData      <= 32'h0;
    end else begin
      if (memRespValid && memRespReady) memRespValid <= 1'b0;
      if (memReqValid && memReqReady) begin
        memRespValid <= 1'b1;
        memData      <= memRead(memAddr);
        readLog.push_back(memAddr);
      end
    end
  end

  function automatic logic [31:0] readAt(input int i);
    if (i < readLog.size()) return readLog[i];
    return 32'hFFFFFFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic issueRequest(input logic [31:0] va);
    readLog.delete();
    @(negedge clk);
    reqValid = 1'b1;
    vaddrIn  = va;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Waits for the response, captures it, holds it for a while, then accepts it.
  task automatic collectResponse(input int hold);
    int cycles;
    cycles = 1;
    while (!respValid && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    if (!respValid) checkOutput("respTimeout", 32'(respValid), 32'd1);
    walkLatency = cycles;
    gotPte      = pte;
    gotLevel    = 32'(level);
    gotFault    = 32'(fault);
    stableOk    = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!respValid || pte !== gotPte || 32'(fault) !== gotFault || reqReady) stableOk = 1'b0;
    end
    respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    respReady = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] va, input int hold);
    issueRequest(va);
    collectResponse(hold);
  endtask

  task automatic pulseFlush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expReads;
    logic bpOk;
    logic noResp;
    checkCount  = 0;
    passCount   = 0;
    rst         = 1'b1;
    reqValid    = 1'b0;
    vaddrIn     = 32'h0;
    rootIn      = 32'h1000;
    flush       = 1'b0;
    respReady   = 1'b0;
    memReqReady = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstReqReady", 32'(reqReady), 32'd1);
    checkOutput("rstRespValid", 32'(respValid), 32'd0);
    checkOutput("rstMemReqValid", 32'(memReqValid), 32'd0);
    checkOutput("rstMemAddr", memAddr, 32'h0);
    checkOutput("rstPte", pte, 32'h0);
    checkOutput("rstFault", 32'(fault), 32'd0);

    $display("[TB] two-level walk");
    applyStimulus(32'h00000000, 0);
    checkOutput("w0Latency", 32'(walkLatency), 32'd5);
    checkOutput("w0Reads", 32'(readLog.size()), 32'd2);
    checkOutput("w0Read0", readAt(0), 32'h1000);
    checkOutput("w0Read1", readAt(1), 32'h2000);
    checkOutput("w0Pte", gotPte, 32'h1000000F);
    checkOutput("w0Level", gotLevel, 32'd0);
    checkOutput("w0Fault", gotFault, 32'd0);

    applyStimulus(32'h00401000, 0);
    checkOutput("w1Read0", readAt(0), 32'h1004);
    checkOutput("w1Read1", readAt(1), 32'h3004);
    checkOutput("w1Pte", gotPte, 32'h2100000F);
    checkOutput("w1Level", gotLevel, 32'd0);
    checkOutput("w1Fault", gotFault, 32'd0);

    $display("[TB] superpage, faults and response backpressure");
    applyStimulus(32'h00800000, 4);
    checkOutput("spReads", 32'(readLog.size()), 32'd1);
    checkOutput("spRead0", readAt(0), 32'h1008);
    checkOutput("spPte", gotPte, 32'h1240000F);
    checkOutput("spLevel", gotLevel, 32'd1);
    checkOutput("spFault", gotFault, 32'd0);
    checkOutput("respStable", 32'(stableOk), 32'd1);
    checkOutput("reqReadyAfterResp", 32'(reqReady), 32'd1);

    applyStimulus(32'h00C00000, 0);
    checkOutput("invRead0", readAt(0), 32'h100C);
    checkOutput("invPte", gotPte, 32'h0);
    checkOutput("invLevel", gotLevel, 32'd1);
    checkOutput("invFault", gotFault, 32'd1);

    applyStimulus(32'h01000000, 0);
    checkOutput("misPte", gotPte, 32'h0000100F);
    checkOutput("misLevel", gotLevel, 32'd1);
    checkOutput("misFault", gotFault, 32'd1);

    applyStimulus(32'h01400000, 0);
    checkOutput("wnrPte", gotPte, 32'h0);
    checkOutput("wnrFault", gotFault, 32'd1);

    applyStimulus(32'h00003000, 0);
    checkOutput("nlRead1", readAt(1), 32'h200C);
    checkOutput("nlPte", gotPte, 32'h00005001);
    checkOutput("nlLevel", gotLevel, 32'd0);
    checkOutput("nlFault", gotFault, 32'd1);

    $display("[TB] memory request backpressure");
    pulseFlush();
    memReqReady = 1'b0;
    issueRequest(32'h00000000);
    bpOk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!memReqValid || memAddr !== 32'h1000) bpOk = 1'b0;
      @(negedge clk);
    end
    checkOutput("bpHeld", 32'(bpOk), 32'd1);
    memReqReady = 1'b1;
    collectResponse(0);
    checkOutput("bpPte", gotPte, 32'h1000000F);

    $display("[TB] last-level table cache");
`ifdef PTW_PDE_CACHE_EN
    expReads = 1;
`else
    expReads = 2;
`endif
    applyStimulus(32'h00001000, 0);
    checkOutput("cacheReads", 32'(readLog.size()), 32'(expReads));
    checkOutput("cacheLastRead", readAt(expReads - 1), 32'h2004);
    checkOutput("cachePte", gotPte, 32'h1100000F);
    checkOutput("cacheLevel", gotLevel, 32'd0);

    pulseFlush();
    applyStimulus(32'h00001000, 0);
    checkOutput("flushReads", 32'(readLog.size()), 32'd2);
    checkOutput("flushRead0", readAt(0), 32'h1000);
    checkOutput("flushPte", gotPte, 32'h1100000F);

    $display("[TB] reset mid-walk");
    issueRequest(32'h00000000);
    for (int i = 0; i < 20 && !memRespReady; i++) @(negedge clk);
    checkOutput("reachedMwait", 32'(memRespReady), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstReqReady", 32'(reqReady), 32'd1);
    checkOutput("midRstMemReqValid", 32'(memReqValid), 32'd0);
    noResp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (respValid) noResp = 1'b0;
      @(negedge clk);
    end
    checkOutput("midRstNoResp", 32'(noResp), 32'd1);
    applyStimulus(32'h00001000, 0);
    checkOutput("postRstReads", 32'(readLog.size()), 32'd2);
    checkOutput("postRstPte", gotPte, 32'h1100000F);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
